// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words,
// writes them to sequential word addresses and holds the CPU in reset until done.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [10:0]       word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

  localparam logic [10:0] DEPTH_C = 11'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        idx_q,   idx_d;
  logic [10:0]       cnt_q,   cnt_d;
  logic [10:0]       total_q, total_d;
  logic [10:0]       req_words;

  function automatic logic [10:0] clamp_count(input logic [10:0] wc);
    return (wc > DEPTH_C) ? DEPTH_C : wc;
  endfunction

  assign req_words = clamp_count(word_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          total_d = req_words;
          addr_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (req_words == 11'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        // Partial-word state is simply held while the source stalls.
        if (byte_valid) begin
          wdata_d[{idx_q, 3'b000} +: 8] = byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q + 11'd1 == total_q) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + 11'd1;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_ready = (state_q == LOAD);
  assign mem_we     = (state_q == WRITE);
  assign busy       = (state_q == LOAD) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign cpu_reset  = (state_q != DONE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus random byte streams checked against
// a list-based model of which words must land at which addresses.
module tb_imem_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  bytes_q[$];
  int          got_addr[$];
  logic [31:0] got_data[$];

  imem_loader #(.ADDR_W(10), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(int'(mem_addr));
      got_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive bytes_q through the handshake; mode 0 = always valid, 1 = every other cycle, 2 = random.
  task automatic feed(input int mode, input bit glitch, output int cycles);
    int i = 0;
    int cyc = 0;
    bit v;
    bit pulsed = 0;
    while (i < bytes_q.size() && cyc < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      byte_valid = v;
      byte_data  = bytes_q[i];
      start      = 1'b0;
      if (glitch && !pulsed && i == 2) begin
        start      = 1'b1;
        word_count = 11'd5;
        pulsed     = 1'b1;
      end
      @(negedge clk);
      if (v && byte_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    cycles     = cyc;
    if (cyc >= 20000) check("feed_bound", 32'(i), 32'(bytes_q.size()));
  endtask

  task automatic do_load(input int wc, input int mode, input bit glitch, input bit preset,
                         input string tag);
    int n;
    int cyc;
    int k;
    n = (wc > DEPTH) ? DEPTH : wc;
    if (!preset) begin
      bytes_q.delete();
      repeat (4 * n) bytes_q.push_back(8'($urandom));
    end
    got_addr.delete();
    got_data.delete();
    start      = 1'b1;
    word_count = 11'(wc);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_cpurst_on_start"}, 32'(cpu_reset), 32'd1);
    check({tag, "_busy_on_start"}, 32'(busy), 32'd1);
    feed(mode, glitch, cyc);
    if (mode == 0) check({tag, "_cycles"}, 32'(cyc), 32'(5 * n - 1));
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(n));
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(got_addr[i]), 32'(i));
      check({tag, "_data"}, got_data[i],
            {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    start      = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle must refuse bytes and never write.
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_byte_ready", 32'(byte_ready), 32'd0);
    check("idle_nwrites", 32'(got_addr.size()), 32'd0);
    @(posedge clk); #1;
    byte_valid = 1'b0;

    bytes_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load(2, 0, 1'b0, 1'b1, "two_words");
    check("two_words_w0", (got_data.size() > 0) ? got_data[0] : 32'hx, 32'h0000_0013);
    check("two_words_w1", (got_data.size() > 1) ? got_data[1] : 32'hx, 32'h0010_0093);

    bytes_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(1, 1, 1'b0, 1'b1, "toggle");
    check("toggle_word", (got_data.size() > 0) ? got_data[0] : 32'hx, 32'hDEAD_BEEF);

    got_addr.delete();
    got_data.delete();
    start      = 1'b1;
    word_count = 11'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_cpurst", 32'(cpu_reset), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("zero_nwrites", 32'(got_addr.size()), 32'd0);
    @(posedge clk); #1;

    // Reset after two bytes of the second word of a three-word load.
    got_addr.delete();
    got_data.delete();
    bytes_q.delete();
    repeat (6) bytes_q.push_back(8'($urandom));
    start      = 1'b1;
    word_count = 11'd3;
    @(posedge clk); #1;
    start = 1'b0;
    feed(2, 1'b0, cyc);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check("midrst_byte_ready", 32'(byte_ready), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    byte_valid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    check("midrst_nwrites", 32'(got_addr.size()), 32'd1);
    check("midrst_w0", (got_data.size() > 0) ? got_data[0] : 32'hx,
          {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]});
    @(posedge clk); #1;
    do_load(3, 2, 1'b0, 1'b0, "reload");

    do_load(2, 0, 1'b1, 1'b0, "busy_start");

    for (int t = 0; t < 6; t++) begin
      do_load(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 1'b0, 1'b0, "rand");
    end

    do_load(1500, 0, 1'b0, 1'b0, "clamp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the word-address width of the instruction memory written.
REQ-002 SHALL have parameter DEPTH, default 1024, the maximum number of 32-bit words loadable.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-006 SHALL have port word_count  input  11  number of words to load; latched on accepted start.
REQ-007 SHALL have port byte_valid  input  1  source has a byte on byte_data.
REQ-008 SHALL have port byte_data  input  8  program byte stream, little-endian within each word.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 SHALL have port mem_addr  output  ADDR_W  word address of the write.
REQ-012 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have port cpu_reset  output  1  holds the processor in reset until a load completes.
REQ-014 SHALL have ports busy and done  output  1 each  busy high in LOAD/WRITE; done high in DONE.

Function
REQ-015 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-016 IDLE: byte_ready=0, mem_we=0, cpu_reset=1; on start go to LOAD with mem_addr=0, byte index=0, word counter=0.
REQ-017 Latched word_count SHALL clamp to DEPTH when greater than DEPTH.
REQ-018 word_count=0 with start SHALL go directly to DONE with no writes.
REQ-019 A byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 in LOAD and 0 in all other states.
REQ-020 The k-th accepted byte of a word (k=0..3) SHALL be placed in mem_wdata bits [8k+7:8k].
REQ-021 On acceptance of byte k=3 the next state SHALL be WRITE; mem_we SHALL be high exactly in the following cycle (latency 1) with mem_addr and the complete word stable.
REQ-022 WRITE lasts one cycle; then if word counter+1 equals latched count go to DONE, else increment mem_addr, reset byte index, return to LOAD.
REQ-023 byte_valid low in LOAD SHALL stall without losing partial-word state; no timeout.
REQ-024 Throughput SHALL be at most 4 bytes per 5 cycles.
REQ-025 DONE: cpu_reset=0, done=1, byte_ready=0; start SHALL restart a load (cpu_reset=1 the next cycle).
REQ-026 start while busy SHALL be ignored.
REQ-027 mem_addr SHALL never exceed DEPTH-1; the final write of a DEPTH-word load is to DEPTH-1 with no wrap.
REQ-028 mem_wdata and mem_addr SHALL be registered outputs; mem_we SHALL be asserted only in WRITE.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0.
REQ-030 reset mid-load SHALL abandon the partial word and counters; words already written are not erased; reset dominates a coincident start.

Verification
REQ-031 start, word_count=2, bytes 13,00,00,00,93,00,10,00 back-to-back -> writes 0x00000013 at addr 0, 0x00100093 at addr 1; done=1, cpu_reset=0 after last write.
REQ-032 byte_valid toggled every other cycle during load of 0xDEADBEEF (bytes EF,BE,AD,DE) -> single write of 0xDEADBEEF at addr 0; no write before 4th byte.
REQ-033 word_count=0 start -> DONE next cycle, mem_we never asserted, cpu_reset=0.
REQ-034 reset asserted after 2 bytes of word 1 of a 3-word load -> IDLE, cpu_reset=1, no further mem_we; new start reloads from addr 0.
REQ-035 word_count=1500 -> exactly 1024 writes, addresses 0..1023 in order, done=1.
REQ-036 start pulsed during LOAD -> ignored; load completes with original count.
